rr_mux41_stream: RTL
====================

Name: rr_mux41_stream

Overview:
4-to-1 streaming multiplexer with round-robin arbitration. It is the transmit-side counterpart of the 1-to-4 demux. It merges four valid/ready input channels onto one registered output stream. Each output beat carries a 2-bit channel tag (out_sel) that a downstream demux14 uses directly as its select input.

Parameters:
DATA_W, 8, width of each channel's data bus.
BURST_LEN, 1, maximum consecutive beats granted to one channel before arbitration moves on (legal range 1..255).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  4  per-channel valid; bit k belongs to channel k.
in_data  input  4*DATA_W  channel k data at bits [k*DATA_W +: DATA_W].
in_ready  output  4  per-channel accept; at most one bit high in any cycle.
out_valid  output  1  output beat present.
out_data  output  DATA_W  data of the output beat.
out_sel  output  2  source channel index of the output beat.
out_ready  input  1  downstream accepts the output beat.

Behaviour:
- Reset is asynchronous on rst_n low. Values during and after reset: out_valid=0, out_data=0, out_sel=0, rr_ptr=0, beat_cnt=0, state=ARB. in_ready=0 while rst_n is low.
- Transfer rules:
  - An input transfer on channel k occurs when in_valid[k] && in_ready[k].
  - An output transfer occurs when out_valid && out_ready.
- Load enable: load_en = !out_valid || out_ready.
  - When load_en=0, all in_ready are 0.
  - When load_en=0, out_valid, out_data and out_sel hold stable.
- Grant (combinational):
  - In state ARB: grant = the first k with in_valid[k]=1, searched in the order rr_ptr, rr_ptr+1, ..., rr_ptr+3 (mod 4).
  - In state HOLD: grant = cur_ch, provided in_valid[cur_ch]=1.
  - If in HOLD and in_valid[cur_ch]=0, the same cycle falls back to the ARB search starting at cur_ch+1. No bubble is inserted.
- in_ready[grant] = load_en when a grant exists; all other bits are 0. in_ready may depend combinationally on in_valid and out_ready.
- On an input transfer from channel g, at the next edge: out_valid=1, out_data=in_data[g], out_sel=g.
  - Latency: accepted in cycle N, visible at the output in cycle N+1.
  - Throughput: one beat per cycle when out_ready stays high.
- When load_en=1 and no grant exists: out_valid<=0. out_data and out_sel keep their last values (don't-care while out_valid=0).
- State machine, two states (ARB, HOLD), with beat_cnt 8-bit and cur_ch 2-bit:
  - ARB with transfer from g: cur_ch<=g, beat_cnt<=1.
    - If BURST_LEN=1: rr_ptr<=g+1 mod 4, stay in ARB.
    - Else: go to HOLD.
  - HOLD with transfer from cur_ch: beat_cnt++.
    - If beat_cnt+1 == BURST_LEN: rr_ptr<=cur_ch+1, go to ARB.
  - HOLD where cur_ch is not valid: treated as an ARB cycle (rules above), and rr_ptr<=cur_ch+1 if nothing is granted.
  - No transfer while load_en=0: state, beat_cnt and rr_ptr hold.
- Boundaries:
  - rr_ptr wraps 3 to 0.
  - A single active channel may be granted back-to-back indefinitely; no forced idle cycle.
  - A simultaneous output transfer and new input transfer in one cycle is a replace, with no gap.
  - Reset mid-burst returns to ARB with rr_ptr=0, and the in-flight output beat is dropped.
- Fairness: with all channels continuously valid, each channel receives exactly BURST_LEN beats per round of 4*BURST_LEN beats.

Test Plan:
- Reset, then hold rst_n=0 for 3 cycles with all in_valid=1 -> out_valid=0 and in_ready=4'b0000 throughout. After release, the first beat has out_sel=0.
- Only channel 2 valid with data 8'hA5, out_ready=1 -> in_ready=4'b0100 in cycle N. Cycle N+1: out_valid=1, out_data=8'hA5, out_sel=2. out_valid returns to 0 the cycle after in_valid drops.
- All four valid with data 8'h10/8'h11/8'h12/8'h13, BURST_LEN=1, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3 and out_data 10,11,12,13,10,11,12,13 with no gaps.
- Backpressure: out_valid=1 with out_data=8'h12 while out_ready=0 for 3 cycles -> out_data and out_sel stable and in_ready=4'b0000. Raising out_ready resumes with the next channel (sel 3).
- BURST_LEN=2, all four valid -> out_sel sequence 0,0,1,1,2,2,3,3,0. Repeat with channel 1 dropping valid after one beat -> sequence 0,0,1,2,2,3,3 with no bubble.
- Asynchronous reset asserted mid-cycle during a HOLD burst on channel 3 -> out_valid falls before the next clock edge. After release, arbitration restarts at channel 0.

Source files
------------

// File: rtl/rr_mux41_stream.sv
// 4-to-1 round-robin stream mux with optional per-channel bursts. The output beat is registered and tagged with its source.
// Latency 1 cycle from input accept to output beat; in_ready is gated by the output slot being free or draining.
module rr_mux41_stream #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            in_valid,
  input  logic [4*DATA_W-1:0]   in_data,
  output logic [3:0]            in_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [1:0]            out_sel,
  input  logic                  out_ready
);

  typedef enum logic {ARB, HOLD} state_t;

  localparam logic [7:0] BURST_C = 8'(BURST_LEN);

  state_t              state_q, state_d;
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic [1:0]          cur_ch_q, cur_ch_d;
  logic [7:0]          beat_cnt_q, beat_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [1:0]          out_sel_q, out_sel_d;

  logic                load_en;
  logic                hold_hit;
  logic                grant_vld;
  logic [1:0]          grant_idx;
  logic [1:0]          search_base;
  logic [1:0]          probe_idx;
  logic                xfer;
  logic [7:0]          cnt_inc;

  // A HOLD whose owner went idle searches from the owner's successor in the same cycle.
  always_comb begin
    load_en     = !out_valid_q || out_ready;
    hold_hit    = (state_q == HOLD) && in_valid[cur_ch_q];
    search_base = (state_q == HOLD) ? cur_ch_q + 2'd1 : rr_ptr_q;
    grant_vld   = hold_hit;
    grant_idx   = cur_ch_q;
    probe_idx   = 2'd0;
    if (!hold_hit) begin
      for (int i = 3; i >= 0; i--) begin
        probe_idx = search_base + 2'(i);
        if (in_valid[probe_idx]) begin
          grant_vld = 1'b1;
          grant_idx = probe_idx;
        end
      end
    end
    xfer     = load_en && grant_vld;
    in_ready = (rst_n && xfer) ? (4'b0001 << grant_idx) : 4'b0000;
    cnt_inc  = beat_cnt_q + 8'd1;
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cur_ch_d    = cur_ch_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(grant_idx)*DATA_W +: DATA_W];
      out_sel_d   = grant_idx;
      if (hold_hit) begin
        beat_cnt_d = cnt_inc;
        if (cnt_inc == BURST_C) begin
          rr_ptr_d = cur_ch_q + 2'd1;
          state_d  = ARB;
        end
      end else begin
        cur_ch_d   = grant_idx;
        beat_cnt_d = 8'd1;
        if (BURST_C == 8'd1) begin
          rr_ptr_d = grant_idx + 2'd1;
          state_d  = ARB;
        end else begin
          state_d  = HOLD;
        end
      end
    end else if (load_en) begin
      out_valid_d = 1'b0;
      if (state_q == HOLD) begin
        rr_ptr_d = cur_ch_q + 2'd1;
        state_d  = ARB;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB;
      rr_ptr_q    <= 2'd0;
      cur_ch_q    <= 2'd0;
      beat_cnt_q  <= 8'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cur_ch_q    <= cur_ch_d;
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule
